// File: rtl/pkg_banco.sv
// Shared types and constants for the register-bank write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pkg_banco;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int N_REGS = 16;

    // One queued writeback: destination register and the value to store.
    typedef struct packed {
        logic [ADDR_W-1:0] reg_dst;
        logic [DATA_W-1:0] dado;
    } req_escrita_t;

    // Grant encoding, also the encoding held in the round-robin pointer.
    localparam logic GNT_ALU = 1'b0;
    localparam logic GNT_MEM = 1'b1;

endpackage

// File: rtl/fifo_escrita.sv
// Small circular FIFO of pending writebacks for one requester.
// Latency: an entry pushed at edge N is visible at head after edge N.
// Backpressure: cheio is set when all DEPTH slots are used; caller must not push then.
//
// Ports: clk, rst_n (async active-low), push/entrada (write side),
//        pop (read side), head (oldest entry), vazio/cheio (registered status).
module fifo_escrita
    import pkg_banco::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  req_escrita_t entrada,
    input  logic         pop,
    output req_escrita_t head,
    output logic         vazio,
    output logic         cheio
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate count register.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    req_escrita_t   mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= entrada;
        end
    end

    assign head  = mem[rd_ptr[PTR_W-1:0]];
    assign vazio = (wr_ptr == rd_ptr);
    assign cheio = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/arbitro_escrita_banco.sv
// Round-robin arbiter of two writeback FIFOs (ALU, memory) onto the single
// bank write port, plus the pending-write scoreboard used for RAW detection.
// Latency: push at edge N into an idle FIFO drives RW=1 after edge N+1.
// Backpressure: reqN_ready is low while FIFO N is full or reset is asserted.
//
// Ports: clk, rst_n (async active-low); req0_* = ALU source, req1_* = memory
//        source (valid/ready/reg/dado); res_valid/res_reg = reservation from
//        issue; regC/dado/RW = registered bank write port; pendente = scoreboard.
module arbitro_escrita_banco #(
    parameter int DATA_W     = pkg_banco::DATA_W,
    parameter int ADDR_W     = pkg_banco::ADDR_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req0_valid,
    output logic                         req0_ready,
    input  logic [ADDR_W-1:0]            req0_reg,
    input  logic [DATA_W-1:0]            req0_dado,
    input  logic                         req1_valid,
    output logic                         req1_ready,
    input  logic [ADDR_W-1:0]            req1_reg,
    input  logic [DATA_W-1:0]            req1_dado,
    input  logic                         res_valid,
    input  logic [ADDR_W-1:0]            res_reg,
    output logic [ADDR_W-1:0]            regC,
    output logic [DATA_W-1:0]            dado,
    output logic                         RW,
    output logic [pkg_banco::N_REGS-1:0] pendente
);

    pkg_banco::req_escrita_t entrada0, entrada1;
    pkg_banco::req_escrita_t head0, head1, head_sel;
    logic vazio0, vazio1, cheio0, cheio1;
    logic push0, push1, pop0, pop1;
    logic gnt_vld, gnt_sel;
    logic ultimo;
    logic [pkg_banco::N_REGS-1:0] set_bits, clr_bits;

    // Ready comes only from registered FIFO state; it is held low in reset
    // so nothing is accepted while the queues are being flushed.
    assign req0_ready = rst_n & ~cheio0;
    assign req1_ready = rst_n & ~cheio1;
    assign push0      = req0_valid & req0_ready;
    assign push1      = req1_valid & req1_ready;

    assign entrada0 = '{reg_dst: req0_reg, dado: req0_dado};
    assign entrada1 = '{reg_dst: req1_reg, dado: req1_dado};

    fifo_escrita #(.DEPTH(FIFO_DEPTH)) u_fifo_alu (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push0),
        .entrada (entrada0),
        .pop     (pop0),
        .head    (head0),
        .vazio   (vazio0),
        .cheio   (cheio0)
    );

    fifo_escrita #(.DEPTH(FIFO_DEPTH)) u_fifo_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push1),
        .entrada (entrada1),
        .pop     (pop1),
        .head    (head1),
        .vazio   (vazio1),
        .cheio   (cheio1)
    );

    // Grant: a lone non-empty FIFO wins; on a tie the one not granted last.
    // Grants only look at registered FIFO state, so there is no bypass path.
    always_comb begin
        gnt_vld = ~vazio0 | ~vazio1;
        if (vazio0) begin
            gnt_sel = pkg_banco::GNT_MEM;
        end else if (vazio1) begin
            gnt_sel = pkg_banco::GNT_ALU;
        end else begin
            gnt_sel = ~ultimo;
        end
    end

    assign pop0     = gnt_vld & (gnt_sel == pkg_banco::GNT_ALU);
    assign pop1     = gnt_vld & (gnt_sel == pkg_banco::GNT_MEM);
    assign head_sel = (gnt_sel == pkg_banco::GNT_MEM) ? head1 : head0;

    always_comb begin
        set_bits = '0;
        clr_bits = '0;
        if (res_valid) begin
            set_bits[res_reg] = 1'b1;
        end
        if (gnt_vld) begin
            clr_bits[head_sel.reg_dst] = 1'b1;
        end
    end

    // RW is a flop output so the level-sensitive bank never sees a glitch.
    // A reservation landing on the same edge as its clear wins, since it
    // belongs to a newer producer that is still outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ultimo   <= pkg_banco::GNT_MEM;
            RW       <= 1'b0;
            regC     <= '0;
            dado     <= '0;
            pendente <= '0;
        end else begin
            RW       <= gnt_vld;
            pendente <= (pendente & ~clr_bits) | set_bits;
            if (gnt_vld) begin
                regC   <= head_sel.reg_dst;
                dado   <= head_sel.dado;
                ultimo <= gnt_sel;
            end
        end
    end

endmodule
